// File: rtl/ex_stage_fu.sv
// ex_stage_fu: execute stage between ID and MEM.
//   ALU-class ops (in_fu_sel == 0) are registered straight into the output
//   stage with latency 1. Multi-cycle ops are issued to external functional
//   unit k (the lowest set bit of in_fu_sel) over a valid/ready request. The
//   stage then waits for that unit's response and registers it as the result.
// Ports:
//   clk, rst (async, active-low), flush (sync kill)
//   in_*          upstream op and its valid/ready handshake
//   fu_req_*      per-FU request valid/ready plus shared operands
//   fu_resp_*     per-FU response valid/ready plus packed result data
//   busy          a multi-cycle op is outstanding (including a drain)
//   out_*         registered payload with its valid/ready handshake
module ex_stage_fu #(
  parameter int unsigned     XLEN   = 32,
  parameter int unsigned     DEST_W = 5,
  parameter int unsigned     NUM_FU = 2,
  parameter int unsigned     SIDE_W = 16,
  parameter logic [XLEN-1:0] PC_RST = XLEN'(32'h1c000000)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [XLEN-1:0]        in_pc,
  input  logic [XLEN-1:0]        in_src1,
  input  logic [XLEN-1:0]        in_src2,
  input  logic [XLEN-1:0]        in_alu_res,
  input  logic [NUM_FU-1:0]      in_fu_sel,
  input  logic                   in_gr_we,
  input  logic [DEST_W-1:0]      in_dest,
  input  logic [SIDE_W-1:0]      in_side,
  output logic [NUM_FU-1:0]      fu_req_valid,
  input  logic [NUM_FU-1:0]      fu_req_ready,
  output logic [XLEN-1:0]        fu_req_src1,
  output logic [XLEN-1:0]        fu_req_src2,
  input  logic [NUM_FU-1:0]      fu_resp_valid,
  input  logic [NUM_FU*XLEN-1:0] fu_resp_data,
  output logic [NUM_FU-1:0]      fu_resp_ready,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_pc,
  output logic [XLEN-1:0]        out_result,
  output logic                   out_gr_we,
  output logic [DEST_W-1:0]      out_dest,
  output logic [SIDE_W-1:0]      out_side
);

  localparam int unsigned K_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DRAIN} state_e;

  state_e              state_q, state_d;
  logic [K_W-1:0]      k_q, k_d;
  logic [XLEN-1:0]     lat_pc_q, lat_pc_d;
  logic [XLEN-1:0]     lat_src1_q, lat_src1_d;
  logic [XLEN-1:0]     lat_src2_q, lat_src2_d;
  logic                lat_gr_we_q, lat_gr_we_d;
  logic [DEST_W-1:0]   lat_dest_q, lat_dest_d;
  logic [SIDE_W-1:0]   lat_side_q, lat_side_d;
  logic                out_valid_q, out_valid_d;
  logic [XLEN-1:0]     out_pc_q, out_pc_d;
  logic [XLEN-1:0]     out_result_q, out_result_d;
  logic                out_gr_we_q, out_gr_we_d;
  logic [DEST_W-1:0]   out_dest_q, out_dest_d;
  logic [SIDE_W-1:0]   out_side_q, out_side_d;

  logic [NUM_FU-1:0]   sel_oh;
  logic [K_W-1:0]      in_k;
  logic [XLEN-1:0]     resp_data;
  logic                out_free, fire_in, fire_out, is_fu, req_fire, resp_fire;

  assign sel_oh        = NUM_FU'(1) << k_q;
  assign out_free      = !out_valid_q || out_ready;
  assign in_ready      = (state_q == S_IDLE) && out_free && !flush;
  assign fire_in       = in_valid && in_ready;
  assign fire_out      = out_valid_q && out_ready;
  assign is_fu         = |in_fu_sel;
  assign fu_req_valid  = (state_q == S_REQ) ? sel_oh : '0;
  // A drain always accepts: the result is discarded, so output backpressure is irrelevant.
  assign fu_resp_ready = (((state_q == S_RESP) && out_free) || (state_q == S_DRAIN)) ? sel_oh : '0;
  assign req_fire      = |(fu_req_valid & fu_req_ready);
  assign resp_fire     = |(fu_resp_valid & fu_resp_ready);
  assign fu_req_src1   = lat_src1_q;
  assign fu_req_src2   = lat_src2_q;
  assign busy          = (state_q != S_IDLE);

  assign out_valid  = out_valid_q;
  assign out_pc     = out_pc_q;
  assign out_result = out_result_q;
  assign out_gr_we  = out_gr_we_q;
  assign out_dest   = out_dest_q;
  assign out_side   = out_side_q;

  // Lowest set select bit wins: scan from the top so the last write is the lowest index.
  always_comb begin
    in_k = '0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      if (in_fu_sel[NUM_FU-1-i]) in_k = K_W'(NUM_FU-1-i);
    end
  end

  always_comb begin
    resp_data = '0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      if (K_W'(i) == k_q) resp_data = fu_resp_data[i*XLEN +: XLEN];
    end
  end

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    lat_pc_d     = lat_pc_q;
    lat_src1_d   = lat_src1_q;
    lat_src2_d   = lat_src2_q;
    lat_gr_we_d  = lat_gr_we_q;
    lat_dest_d   = lat_dest_q;
    lat_side_d   = lat_side_q;
    out_valid_d  = out_valid_q;
    out_pc_d     = out_pc_q;
    out_result_d = out_result_q;
    out_gr_we_d  = out_gr_we_q;
    out_dest_d   = out_dest_q;
    out_side_d   = out_side_q;

    if (fire_in && is_fu) begin
      k_d         = in_k;
      lat_pc_d    = in_pc;
      lat_src1_d  = in_src1;
      lat_src2_d  = in_src2;
      lat_gr_we_d = in_gr_we;
      lat_dest_d  = in_dest;
      lat_side_d  = in_side;
    end

    // A request that fires alongside flush is already owned by the FU, so its response must be drained.
    case (state_q)
      S_IDLE:  if (fire_in && is_fu) state_d = S_REQ;
      S_REQ: begin
        if (req_fire)   state_d = flush ? S_DRAIN : S_RESP;
        else if (flush) state_d = S_IDLE;
      end
      S_RESP: begin
        if (resp_fire)  state_d = S_IDLE;
        else if (flush) state_d = S_DRAIN;
      end
      S_DRAIN: if (resp_fire) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      out_valid_d = 1'b0;
    end else if (fire_in && !is_fu) begin
      out_valid_d  = 1'b1;
      out_pc_d     = in_pc;
      out_result_d = in_alu_res;
      out_gr_we_d  = in_gr_we;
      out_dest_d   = in_dest;
      out_side_d   = in_side;
    end else if ((state_q == S_RESP) && resp_fire) begin
      out_valid_d  = 1'b1;
      out_pc_d     = lat_pc_q;
      out_result_d = resp_data;
      out_gr_we_d  = lat_gr_we_q;
      out_dest_d   = lat_dest_q;
      out_side_d   = lat_side_q;
    end else if (fire_out) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      k_q          <= '0;
      lat_pc_q     <= '0;
      lat_src1_q   <= '0;
      lat_src2_q   <= '0;
      lat_gr_we_q  <= 1'b0;
      lat_dest_q   <= '0;
      lat_side_q   <= '0;
      out_valid_q  <= 1'b0;
      out_pc_q     <= PC_RST;
      out_result_q <= '0;
      out_gr_we_q  <= 1'b0;
      out_dest_q   <= '0;
      out_side_q   <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      lat_pc_q     <= lat_pc_d;
      lat_src1_q   <= lat_src1_d;
      lat_src2_q   <= lat_src2_d;
      lat_gr_we_q  <= lat_gr_we_d;
      lat_dest_q   <= lat_dest_d;
      lat_side_q   <= lat_side_d;
      out_valid_q  <= out_valid_d;
      out_pc_q     <= out_pc_d;
      out_result_q <= out_result_d;
      out_gr_we_q  <= out_gr_we_d;
      out_dest_q   <= out_dest_d;
      out_side_q   <= out_side_d;
    end
  end

endmodule
